pc_src_ctrl: RTL and testbench

Next-PC sequencer for the multicycle CPU: drives the 3-bit `PC_Src` select of the PC-source multiplexer, plus `pc_write` and `epc_write`. It turns fetch, branch/jump and exception requests from the main control FSM into correctly timed select and write-enable sequences. For exceptions it reads the handler address from the vector table before redirecting the PC.

---
 rtl/cpu_pkg.sv | 72 +++++++
 rtl/pc_src_ctrl.sv | 156 +++++++++++++++
 tb/tb_pc_src_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the next-PC sequencer: PC-source encodings,
// control-transfer kinds, FSM states, exception causes and small helpers.
package cpu_pkg;

  localparam logic [2:0] PC_SRC_ALUOUT = 3'b000;
  localparam logic [2:0] PC_SRC_ALU    = 3'b001;
  localparam logic [2:0] PC_SRC_JUMP   = 3'b010;
  localparam logic [2:0] PC_SRC_EPC    = 3'b011;
  localparam logic [2:0] PC_SRC_LOAD   = 3'b100;

  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_BEQ  = 3'd1,
    KIND_BNE  = 3'd2,
    KIND_BLE  = 3'd3,
    KIND_BGT  = 3'd4,
    KIND_J    = 3'd5,
    KIND_JR   = 3'd6,
    KIND_RTE  = 3'd7
  } ctl_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_BRANCH  = 3'd2,
    ST_EXC_EPC = 3'd3,
    ST_EXC_RD  = 3'd4,
    ST_EXC_LD  = 3'd5
  } state_e;

  localparam logic [1:0] CAUSE_OPCODE   = 2'd0;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;
  localparam logic [1:0] CAUSE_DIV_ZERO = 2'd2;

  // The unused cause code 3 aliases onto the invalid-opcode vector.
  function automatic logic [1:0] norm_cause(input logic [1:0] cause);
    return (cause == 2'd3) ? CAUSE_OPCODE : cause;
  endfunction

  function automatic logic is_cond_branch(input ctl_kind_e kind);
    return (kind == KIND_BEQ) || (kind == KIND_BNE) ||
           (kind == KIND_BLE) || (kind == KIND_BGT);
  endfunction

  function automatic logic branch_taken(input ctl_kind_e kind,
                                        input logic      zero,
                                        input logic      gt);
    logic taken;
    taken = 1'b1;
    case (kind)
      KIND_BEQ: taken = zero;
      KIND_BNE: taken = !zero;
      KIND_BLE: taken = zero | !gt;
      KIND_BGT: taken = gt & !zero;
      default:  taken = 1'b1;
    endcase
    return taken;
  endfunction

  function automatic logic [2:0] kind_src(input ctl_kind_e kind);
    logic [2:0] src;
    src = PC_SRC_ALUOUT;
    case (kind)
      KIND_J:   src = PC_SRC_JUMP;
      KIND_JR:  src = PC_SRC_ALU;
      KIND_RTE: src = PC_SRC_EPC;
      default:  src = PC_SRC_ALUOUT;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/pc_src_ctrl.sv
// Next-PC sequencer: turns fetch, branch/jump and exception requests into PC_Src
// and write-enable sequences. Exception path is built only with PC_SRC_CTRL_EXC_EN.
module pc_src_ctrl
  import cpu_pkg::*;
#(
  parameter int          VEC_WAIT = 3,
  parameter logic [31:0] VEC_BASE = 32'd253
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic        ctl_valid,
  output logic        ctl_ready,
  input  logic [2:0]  ctl_kind,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  output logic        exc_ack,
  output logic [2:0]  PC_Src,
  output logic        pc_write,
  output logic        epc_write,
  output logic        vec_rd,
  output logic [31:0] vec_addr,
  output logic        done
);

  state_e     state;
  ctl_kind_e  kind_q;
  ctl_kind_e  kind_in;
  logic [2:0] pc_src_q;
  logic       pc_write_q;
  logic       cond_q;
  logic       done_q;

  assign kind_in = ctl_kind_e'(ctl_kind);

`ifdef PC_SRC_CTRL_EXC_EN
  localparam int CW = (VEC_WAIT > 1) ? $clog2(VEC_WAIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [1:0]    cause_q;
  logic          exc_ack_q;
  logic          epc_write_q;
  logic          vec_rd_q;
  logic [31:0]   vec_addr_q;
`endif

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // the async reset clears everything so an aborted sequence leaves no write behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      kind_q     <= KIND_NONE;
      pc_src_q   <= PC_SRC_ALUOUT;
      pc_write_q <= 1'b0;
      cond_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PC_SRC_CTRL_EXC_EN
      cnt_q       <= '0;
      cause_q     <= CAUSE_OPCODE;
      exc_ack_q   <= 1'b0;
      epc_write_q <= 1'b0;
      vec_rd_q    <= 1'b0;
      vec_addr_q  <= '0;
`endif
    end else begin
      pc_src_q   <= PC_SRC_ALUOUT;
      pc_write_q <= 1'b0;
      cond_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PC_SRC_CTRL_EXC_EN
      exc_ack_q   <= 1'b0;
      epc_write_q <= 1'b0;
      vec_rd_q    <= 1'b0;
      vec_addr_q  <= '0;
`endif
      case (state)
        ST_IDLE: begin
`ifdef PC_SRC_CTRL_EXC_EN
          if (exc_req) begin
            state       <= ST_EXC_EPC;
            cause_q     <= norm_cause(exc_cause);
            exc_ack_q   <= 1'b1;
            epc_write_q <= 1'b1;
            pc_src_q    <= PC_SRC_ALU;
          end else
`endif
          if (ctl_valid && kind_in != KIND_NONE) begin
            state      <= ST_BRANCH;
            kind_q     <= kind_in;
            pc_write_q <= 1'b1;
            cond_q     <= is_cond_branch(kind_in);
            pc_src_q   <= kind_src(kind_in);
          end else if (fetch_req) begin
            state      <= ST_FETCH;
            pc_write_q <= 1'b1;
            pc_src_q   <= PC_SRC_ALU;
          end else if (ctl_valid) begin
            done_q <= 1'b1;
          end
        end
        ST_FETCH, ST_BRANCH: begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end
`ifdef PC_SRC_CTRL_EXC_EN
        ST_EXC_EPC: begin
          state      <= ST_EXC_RD;
          vec_rd_q   <= 1'b1;
          vec_addr_q <= VEC_BASE + {30'd0, cause_q};
          cnt_q      <= CW'(VEC_WAIT - 1);
        end
        ST_EXC_RD: begin
          // The counter stops at zero, so it never wraps.
          if (cnt_q == '0) begin
            state      <= ST_EXC_LD;
            pc_write_q <= 1'b1;
            pc_src_q   <= PC_SRC_LOAD;
          end else begin
            cnt_q      <= cnt_q - CW'(1);
            vec_rd_q   <= 1'b1;
            vec_addr_q <= vec_addr_q;
          end
        end
        ST_EXC_LD: begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Conditional branches resolve against the flags present while in BRANCH.
  assign pc_write  = pc_write_q & (~cond_q | branch_taken(kind_q, alu_zero, alu_gt));
  assign PC_Src    = pc_src_q;
  assign done      = done_q;
  assign ctl_ready = (state == ST_IDLE);

`ifdef PC_SRC_CTRL_EXC_EN
  assign exc_ack   = exc_ack_q;
  assign epc_write = epc_write_q;
  assign vec_rd    = vec_rd_q;
  assign vec_addr  = vec_addr_q;
`else
  logic unused_exc;
  assign unused_exc = ^{exc_req, exc_cause, VEC_BASE, VEC_WAIT};
  assign exc_ack    = 1'b0;
  assign epc_write  = 1'b0;
  assign vec_rd     = 1'b0;
  assign vec_addr   = 32'd0;
`endif

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Self-checking bench for pc_src_ctrl: each request is expanded by a transaction-level
// model into its expected per-cycle output timeline; works with or without PC_SRC_CTRL_EXC_EN.
module tb_pc_src_ctrl;

`ifdef PC_SRC_CTRL_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req, ctl_valid, alu_zero, alu_gt, exc_req;
  logic [2:0]  ctl_kind;
  logic [1:0]  exc_cause;

  logic        ctl_ready, exc_ack, pc_write, epc_write, vec_rd, done;
  logic [2:0]  pc_src;
  logic [31:0] vec_addr;

  logic        w1_ready, w1_ack, w1_pc_write, w1_epc_write, w1_vec_rd, w1_done;
  logic [2:0]  w1_pc_src;
  logic [31:0] w1_vec_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_src_ctrl dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .ctl_valid(ctl_valid),
    .ctl_ready(ctl_ready), .ctl_kind(ctl_kind), .alu_zero(alu_zero), .alu_gt(alu_gt),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_ack(exc_ack), .PC_Src(pc_src),
    .pc_write(pc_write), .epc_write(epc_write), .vec_rd(vec_rd), .vec_addr(vec_addr),
    .done(done)
  );

  pc_src_ctrl #(.VEC_WAIT(1)) dut_w1 (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .ctl_valid(ctl_valid),
    .ctl_ready(w1_ready), .ctl_kind(ctl_kind), .alu_zero(alu_zero), .alu_gt(alu_gt),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_ack(w1_ack), .PC_Src(w1_pc_src),
    .pc_write(w1_pc_write), .epc_write(w1_epc_write), .vec_rd(w1_vec_rd),
    .vec_addr(w1_vec_addr), .done(w1_done)
  );

  typedef struct {
    logic        pw, ew, ack, vr, dn, rdy;
    logic [2:0]  src;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t idle_cycle();
    exp_t e;
    e.pw = 0; e.ew = 0; e.ack = 0; e.vr = 0; e.dn = 0; e.rdy = 1;
    e.src = 3'b000; e.addr = 32'd0;
    return e;
  endfunction

  // Expands one request into the cycles following its acceptance edge.
  function automatic void build_expect(input bit ex, input logic [1:0] cause, input bit cv,
                                       input logic [2:0] kind, input bit fr, input bit z,
                                       input bit g, input int wait_n);
    exp_t e;
    bit   taken;
    int   c;
    exp_q.delete();
    e = idle_cycle();
    if (EXC_ON && ex) begin
      c = (cause == 2'd3) ? 0 : int'(cause);
      e.rdy = 0; e.ack = 1; e.ew = 1; e.src = 3'b001;
      exp_q.push_back(e);
      e = idle_cycle(); e.rdy = 0; e.vr = 1; e.addr = 32'(253 + c);
      repeat (wait_n) exp_q.push_back(e);
      e = idle_cycle(); e.rdy = 0; e.pw = 1; e.src = 3'b100;
      exp_q.push_back(e);
      e = idle_cycle(); e.dn = 1;
      exp_q.push_back(e);
    end else if (cv && kind != 3'd0) begin
      case (kind)
        3'd1:    taken = z;
        3'd2:    taken = !z;
        3'd3:    taken = z || !g;
        3'd4:    taken = g && !z;
        default: taken = 1;
      endcase
      e.rdy = 0; e.pw = taken;
      e.src = (kind == 3'd5) ? 3'b010 : (kind == 3'd6) ? 3'b001 :
              (kind == 3'd7) ? 3'b011 : 3'b000;
      exp_q.push_back(e);
      e = idle_cycle(); e.dn = 1;
      exp_q.push_back(e);
    end else if (fr) begin
      e.rdy = 0; e.pw = 1; e.src = 3'b001;
      exp_q.push_back(e);
      e = idle_cycle(); e.dn = 1;
      exp_q.push_back(e);
    end else if (cv) begin
      e.dn = 1;
      exp_q.push_back(e);
    end else begin
      exp_q.push_back(e);
    end
  endfunction

  task automatic zero_inputs();
    fetch_req = 0; ctl_valid = 0; ctl_kind = 3'd0; exc_req = 0; exc_cause = 2'd0;
    alu_zero = 0; alu_gt = 0;
  endtask

  task automatic junk_inputs();
    fetch_req = 1'($urandom); ctl_valid = 1'($urandom); ctl_kind = 3'($urandom);
    exc_req = 1'($urandom); exc_cause = 2'($urandom);
    alu_zero = 1'($urandom); alu_gt = 1'($urandom);
  endtask

  // Presents one request in IDLE and checks every cycle until the FSM is back in IDLE.
  // While busy, random junk is driven on all inputs to show they are ignored.
  task automatic run_txn(input string tag, input bit ex, input logic [1:0] cause,
                         input bit cv, input logic [2:0] kind, input bit fr,
                         input bit z, input bit g);
    exp_t e;
    build_expect(ex, cause, cv, kind, fr, z, g, 3);
    exc_req = ex; exc_cause = cause; ctl_valid = cv; ctl_kind = kind;
    fetch_req = fr; alu_zero = z; alu_gt = g;
    @(posedge clk);
    foreach (exp_q[i]) begin
      e = exp_q[i];
      @(negedge clk);
      total++;
      if (ctl_ready !== e.rdy) begin
        bad++; $display("FAIL %s[%0d] ctl_ready got=%b exp=%b", tag, i, ctl_ready, e.rdy);
      end
      total++;
      if (pc_write !== e.pw) begin
        bad++; $display("FAIL %s[%0d] pc_write got=%b exp=%b", tag, i, pc_write, e.pw);
      end
      total++;
      if (epc_write !== e.ew) begin
        bad++; $display("FAIL %s[%0d] epc_write got=%b exp=%b", tag, i, epc_write, e.ew);
      end
      total++;
      if (exc_ack !== e.ack) begin
        bad++; $display("FAIL %s[%0d] exc_ack got=%b exp=%b", tag, i, exc_ack, e.ack);
      end
      total++;
      if (vec_rd !== e.vr) begin
        bad++; $display("FAIL %s[%0d] vec_rd got=%b exp=%b", tag, i, vec_rd, e.vr);
      end
      total++;
      if (done !== e.dn) begin
        bad++; $display("FAIL %s[%0d] done got=%b exp=%b", tag, i, done, e.dn);
      end
      if (e.pw || e.ew) begin
        total++;
        if (pc_src !== e.src) begin
          bad++; $display("FAIL %s[%0d] PC_Src got=%b exp=%b", tag, i, pc_src, e.src);
        end
      end
      if (e.vr) begin
        total++;
        if (vec_addr !== e.addr) begin
          bad++; $display("FAIL %s[%0d] vec_addr got=%0d exp=%0d", tag, i, vec_addr, e.addr);
        end
      end
      if (e.rdy) zero_inputs();
      else       junk_inputs();
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    fetch_req = 1; ctl_valid = 1; ctl_kind = 3'd5; exc_req = 1; exc_cause = 2'd1;
    alu_zero = 1; alu_gt = 1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({pc_write, epc_write, exc_ack, vec_rd, done} !== 5'b0) begin
        bad++; $display("FAIL reset strobes got=%b exp=00000",
                        {pc_write, epc_write, exc_ack, vec_rd, done});
      end
      total++;
      if (pc_src !== 3'b000 || vec_addr !== 32'd0) begin
        bad++; $display("FAIL reset PC_Src/vec_addr got=%b/%0d exp=000/0", pc_src, vec_addr);
      end
    end
    zero_inputs();
    reset_n = 1;
    run_txn("first_fetch", 0, 2'd0, 0, 3'd0, 1, 0, 0);
  endtask

  task automatic test_branches();
    for (int k = 1; k <= 4; k++)
      for (int f = 0; f < 4; f++)
        run_txn($sformatf("branch_k%0d_z%0d_g%0d", k, f[1], f[0]),
                0, 2'd0, 1, 3'(k), 0, f[1], f[0]);
    run_txn("jump_j",   0, 2'd0, 1, 3'd5, 0, 0, 1);
    run_txn("jump_jr",  0, 2'd0, 1, 3'd6, 0, 1, 0);
    run_txn("jump_rte", 0, 2'd0, 1, 3'd7, 0, 0, 0);
    run_txn("ctl_none", 0, 2'd0, 1, 3'd0, 0, 1, 1);
    run_txn("idle",     0, 2'd0, 0, 3'd0, 0, 0, 0);
  endtask

  task automatic test_exceptions();
    run_txn("priority_exc_j_fetch", 1, 2'd1, 1, 3'd5, 1, 0, 0);
    run_txn("cause0", 1, 2'd0, 0, 3'd0, 0, 0, 0);
    run_txn("cause2", 1, 2'd2, 0, 3'd0, 1, 0, 0);
    run_txn("cause3", 1, 2'd3, 0, 3'd0, 0, 0, 0);
    repeat (3) run_txn("exc_held", 1, 2'd2, 0, 3'd0, 0, 1, 0);
  endtask

  task automatic test_random();
    bit ex, cv, fr;
    logic [2:0] kind;
    for (int n = 0; n < 200; n++) begin
      ex   = ($urandom_range(0, 3) == 0);
      cv   = 1'($urandom);
      kind = 3'($urandom);
      fr   = 1'($urandom);
      if (cv && kind == 3'd0) fr = 0;
      run_txn($sformatf("random%0d", n), ex, 2'($urandom), cv, kind, fr,
              1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_abort();
`ifdef PC_SRC_CTRL_EXC_EN
    exc_req = 1; exc_cause = 2'd1;
    @(posedge clk);
    @(negedge clk);
    exc_req = 0;
    @(negedge clk);
    total++;
    if (vec_rd !== 1'b1) begin
      bad++; $display("FAIL abort_in_exc_rd vec_rd got=%b exp=1", vec_rd);
    end
`else
    fetch_req = 1;
    @(posedge clk);
    @(negedge clk);
    fetch_req = 0;
    total++;
    if (pc_write !== 1'b1) begin
      bad++; $display("FAIL abort_in_fetch pc_write got=%b exp=1", pc_write);
    end
`endif
    reset_n = 0;
    #1;
    total++;
    if ({pc_write, epc_write, vec_rd, done} !== 4'b0 || vec_addr !== 32'd0) begin
      bad++; $display("FAIL abort_async got=%b/%0d exp=0000/0",
                      {pc_write, epc_write, vec_rd, done}, vec_addr);
    end
    @(negedge clk);
    reset_n = 1;
    repeat (6) begin
      @(negedge clk);
      total++;
      if ({pc_write, epc_write, done, ctl_ready} !== 4'b0001) begin
        bad++; $display("FAIL abort_after pw/ew/done/ready got=%b exp=0001",
                        {pc_write, epc_write, done, ctl_ready});
      end
    end
  endtask

  task automatic test_wait_one();
`ifdef PC_SRC_CTRL_EXC_EN
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    exc_req = 1; exc_cause = 2'd3;
    @(posedge clk);
    @(negedge clk);
    exc_req = 0;
    total++;
    if ({w1_ack, w1_epc_write} !== 2'b11) begin
      bad++; $display("FAIL wait1_epc ack/epc got=%b exp=11", {w1_ack, w1_epc_write});
    end
    @(negedge clk);
    total++;
    if (w1_vec_rd !== 1'b1 || w1_vec_addr !== 32'd253) begin
      bad++; $display("FAIL wait1_rd vec_rd/addr got=%b/%0d exp=1/253", w1_vec_rd, w1_vec_addr);
    end
    @(negedge clk);
    total++;
    if (w1_vec_rd !== 1'b0 || w1_pc_write !== 1'b1 || w1_pc_src !== 3'b100) begin
      bad++; $display("FAIL wait1_ld vec_rd/pw/src got=%b/%b/%b exp=0/1/100",
                      w1_vec_rd, w1_pc_write, w1_pc_src);
    end
    @(negedge clk);
    total++;
    if (w1_done !== 1'b1 || w1_ready !== 1'b1) begin
      bad++; $display("FAIL wait1_done done/ready got=%b/%b exp=1/1", w1_done, w1_ready);
    end
    repeat (6) @(negedge clk);
`endif
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_branches();
    test_exceptions();
    test_random();
    test_reset_abort();
    test_wait_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
